// File: rtl/char_cross_feature_if.sv
// rtl/char_cross_feature_if.sv - pixel stream, character box and crossing-feature result bundle
//
// master: pixel/box source and result consumer (drives wren, data_in, hcount,
//         lcount, box edges, feat_ready).
// slave : char_cross_feature (drives feat_v, feat_h1, feat_h2, feat_valid,
//         box_err, overrun, black_cnt).
interface char_cross_feature_if #(
    parameter int CNT_W = 3
);
    logic             wren;
    logic [7:0]       data_in;
    logic [8:0]       hcount;
    logic [8:0]       lcount;
    logic [8:0]       Upper_data;
    logic [8:0]       Lower_data;
    logic [8:0]       Left_data;
    logic [8:0]       Right_data;
    logic [CNT_W-1:0] feat_v;
    logic [CNT_W-1:0] feat_h1;
    logic [CNT_W-1:0] feat_h2;
    logic             feat_valid;
    logic             feat_ready;
    logic             box_err;
    logic             overrun;
    logic [16:0]      black_cnt;

    modport master (
        output wren, data_in, hcount, lcount,
        output Upper_data, Lower_data, Left_data, Right_data,
        output feat_ready,
        input  feat_v, feat_h1, feat_h2, feat_valid, box_err, overrun, black_cnt
    );

    modport slave (
        input  wren, data_in, hcount, lcount,
        input  Upper_data, Lower_data, Left_data, Right_data,
        input  feat_ready,
        output feat_v, feat_h1, feat_h2, feat_valid, box_err, overrun, black_cnt
    );
endinterface

// File: rtl/char_cross_feature.sv
// rtl/char_cross_feature.sv - white-to-black crossing features of a segmented character box
//
// Ports:
//   clock      : single clock, all logic on posedge
//   rst        : asynchronous active-high reset
//   bus.slave  : pixel stream (wren/data_in/hcount/lcount), box edges
//                (Upper/Lower/Left/Right_data), result (feat_v/feat_h1/feat_h2,
//                box_err, black_cnt) with feat_valid/feat_ready handshake and
//                overrun pulse.
// Optional feature: define CROSS_BLACK_CNT_EN to count black pixels inside the
// box and present the count on black_cnt; otherwise black_cnt is tied to 0.
module char_cross_feature #(
    parameter int H_ACTIVE = 480,
    parameter int V_ACTIVE = 272,
    parameter int CNT_W    = 3
) (
    input  logic               clock,
    input  logic               rst,
    char_cross_feature_if.slave bus
);
    localparam logic [8:0]       H_LAST   = 9'(H_ACTIVE - 1);
    localparam logic [8:0]       V_LAST   = 9'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state_q;
    logic [8:0]       upper_q, lower_q, left_q, right_q;
    logic [8:0]       mid_x_q, q1_q, q3_q;
    logic             deg_q;
    logic [CNT_W-1:0] v_cnt_q, h1_cnt_q, h2_cnt_q;
    logic             row_hist_q, col_hist_q;
    logic [CNT_W-1:0] feat_v_q, feat_h1_q, feat_h2_q;
    logic             feat_valid_q, box_err_q, overrun_q;

    logic             fe, black, in_rows, in_cols, count_en, row_new, load_res;
    logic             v_inc, h1_inc, h2_inc;
    logic [CNT_W-1:0] v_cnt_d, h1_cnt_d, h2_cnt_d;
    logic [8:0]       h_w, mid_x_d, q1_d, q3_d;
    logic [9:0]       sum10;
    logic             deg_d;

    always_comb begin
        fe       = bus.wren && (bus.hcount == H_LAST) && (bus.lcount == V_LAST);
        black    = (bus.data_in != 8'hff);
        in_rows  = (bus.lcount >= upper_q) && (bus.lcount < lower_q);
        in_cols  = (bus.hcount >= left_q) && (bus.hcount < right_q);
        count_en = (state_q == SCAN) && bus.wren && !deg_q;

        // The first pixel of a row segment is compared against white, not
        // against whatever was streamed before it.
        row_new  = black && ((bus.hcount == left_q) || !row_hist_q);
        h1_inc   = count_en && in_rows && in_cols && (bus.lcount == q1_q) && row_new;
        h2_inc   = count_en && in_rows && in_cols && (bus.lcount == q3_q) && row_new;
        v_inc    = count_en && in_rows && (bus.hcount == mid_x_q) && black &&
                   ((bus.lcount == upper_q) || !col_hist_q);

        v_cnt_d  = (v_inc  && v_cnt_q  != CNT_MAX) ? v_cnt_q  + CNT_W'(1) : v_cnt_q;
        h1_cnt_d = (h1_inc && h1_cnt_q != CNT_MAX) ? h1_cnt_q + CNT_W'(1) : h1_cnt_q;
        h2_cnt_d = (h2_inc && h2_cnt_q != CNT_MAX) ? h2_cnt_q + CNT_W'(1) : h2_cnt_q;

        // Geometry of the box arriving at this frame end, used next frame.
        h_w      = bus.Lower_data - bus.Upper_data;
        sum10    = {1'b0, bus.Left_data} + {1'b0, bus.Right_data};
        mid_x_d  = 9'(sum10 >> 1);
        q1_d     = bus.Upper_data + (h_w >> 2);
        q3_d     = bus.Upper_data + (h_w >> 1) + (h_w >> 2);
        deg_d    = (bus.Lower_data <= bus.Upper_data) || (bus.Right_data <= bus.Left_data);

        // A held, unaccepted result blocks the new one unless it is being
        // accepted on this very edge.
        load_res = fe && (state_q == SCAN) && (!feat_valid_q || bus.feat_ready);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            upper_q      <= '0;
            lower_q      <= '0;
            left_q       <= '0;
            right_q      <= '0;
            mid_x_q      <= '0;
            q1_q         <= '0;
            q3_q         <= '0;
            deg_q        <= 1'b0;
            v_cnt_q      <= '0;
            h1_cnt_q     <= '0;
            h2_cnt_q     <= '0;
            row_hist_q   <= 1'b0;
            col_hist_q   <= 1'b0;
            feat_v_q     <= '0;
            feat_h1_q    <= '0;
            feat_h2_q    <= '0;
            feat_valid_q <= 1'b0;
            box_err_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (bus.wren) begin
                row_hist_q <= black;
                if (bus.hcount == mid_x_q) begin
                    col_hist_q <= black;
                end
            end
            if (fe) begin
                upper_q  <= bus.Upper_data;
                lower_q  <= bus.Lower_data;
                left_q   <= bus.Left_data;
                right_q  <= bus.Right_data;
                mid_x_q  <= mid_x_d;
                q1_q     <= q1_d;
                q3_q     <= q3_d;
                deg_q    <= deg_d;
                v_cnt_q  <= '0;
                h1_cnt_q <= '0;
                h2_cnt_q <= '0;
                if (state_q == IDLE) begin
                    state_q <= SCAN;
                end else if (load_res) begin
                    // The _d values already include the frame-end pixel.
                    feat_v_q     <= v_cnt_d;
                    feat_h1_q    <= h1_cnt_d;
                    feat_h2_q    <= h2_cnt_d;
                    box_err_q    <= deg_q;
                    feat_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else begin
                v_cnt_q  <= v_cnt_d;
                h1_cnt_q <= h1_cnt_d;
                h2_cnt_q <= h2_cnt_d;
                if (feat_valid_q && bus.feat_ready) begin
                    feat_valid_q <= 1'b0;
                end
            end
        end
    end

`ifdef CROSS_BLACK_CNT_EN
    logic [16:0] blk_cnt_q, blk_cnt_d, black_cnt_q;

    always_comb begin
        blk_cnt_d = (count_en && in_rows && in_cols && black && blk_cnt_q != 17'h1ffff)
                    ? blk_cnt_q + 17'(1) : blk_cnt_q;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            blk_cnt_q   <= '0;
            black_cnt_q <= '0;
        end else if (fe) begin
            blk_cnt_q <= '0;
            if (load_res) begin
                black_cnt_q <= blk_cnt_d;
            end
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    assign bus.black_cnt = black_cnt_q;
`else
    assign bus.black_cnt = 17'd0;
`endif

    assign bus.feat_v     = feat_v_q;
    assign bus.feat_h1    = feat_h1_q;
    assign bus.feat_h2    = feat_h2_q;
    assign bus.feat_valid = feat_valid_q;
    assign bus.box_err    = box_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_char_cross_feature.sv
// tb/tb_char_cross_feature.sv - directed scoreboard bench for char_cross_feature
module tb_char_cross_feature;
    localparam int CMAX = 7;

    typedef struct {
        int v;
        int h1;
        int h2;
        int err;
        int blk;
    } res_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    res_t exp_q[$];
    res_t cur;
    int   su = 0, slo = 0, sle = 0, sr = 0;

    char_cross_feature_if #(.CNT_W(3)) bus ();

    char_cross_feature #(.H_ACTIVE(480), .V_ACTIVE(272), .CNT_W(3)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic bit is_black(int pat, int c, int l);
        case (pat)
            1: return (l >= 100 && l < 200 && c >= 150 && c < 250) &&
                      (l < 104 || l >= 196 || c < 154 || c >= 246);
            2: return (l >= 100 && l < 200 && c >= 172 && c <= 178);
            3: return (l == 125 && c >= 150 && c < 200 && ((c - 150) % 2 == 0));
            default: return 1'b0;
        endcase
    endfunction

    // Frame-level reference: walks the whole box and applies the crossing rules.
    function automatic res_t model(int pat, int u, int lo, int le, int r);
        res_t m;
        int h, mid, q1, q3;
        bit b;
        m = '{v: 0, h1: 0, h2: 0, err: 0, blk: 0};
        if (lo <= u || r <= le) begin
            m.err = 1;
            return m;
        end
        h   = lo - u;
        mid = (le + r) / 2;
        q1  = u + h / 4;
        q3  = u + h / 2 + h / 4;
        for (int l = u; l < lo; l++) begin
            for (int c = le; c < r; c++) begin
                b = is_black(pat, c, l);
                if (b && m.blk < 131071) m.blk++;
                if (c == mid && b && (l == u || !is_black(pat, c, l - 1)) && m.v < CMAX) m.v++;
                if (l == q1 && b && (c == le || !is_black(pat, c - 1, l)) && m.h1 < CMAX) m.h1++;
                if (l == q3 && b && (c == le || !is_black(pat, c - 1, l)) && m.h2 < CMAX) m.h2++;
            end
        end
`ifndef CROSS_BLACK_CNT_EN
        m.blk = 0;
`endif
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t e);
        check({tag, "_v"},   32'(bus.feat_v),    e.v);
        check({tag, "_h1"},  32'(bus.feat_h1),   e.h1);
        check({tag, "_h2"},  32'(bus.feat_h2),   e.h2);
        check({tag, "_err"}, 32'(bus.box_err),   e.err);
        check({tag, "_blk"}, 32'(bus.black_cnt), e.blk);
    endtask

    task automatic px(input int c, input int l, input logic [7:0] d);
        bus.wren    = 1'b1;
        bus.hcount  = 9'(c);
        bus.lcount  = 9'(l);
        bus.data_in = d;
        @(posedge clock);
        #1;
        bus.wren = 1'b0;
    endtask

    // Only pixels that can influence a feature are streamed: black pixels,
    // the two sample rows in full and the centre column.
    task automatic drive_frame(input int pat, input int last_line);
        int h, mid, q1, q3;
        bit b;
        h   = slo - su;
        mid = (sle + sr) / 2;
        q1  = su + h / 4;
        q3  = su + h / 2 + h / 4;
        for (int l = su; l < slo && l <= last_line; l++) begin
            for (int c = sle; c < sr; c++) begin
                b = is_black(pat, c, l);
                if (b || l == q1 || l == q3 || c == mid)
                    px(c, l, b ? ((c % 2 == 1) ? 8'hfe : 8'h00) : 8'hff);
            end
        end
    endtask

    task automatic fe(input int u, input int lo, input int le, input int r, input logic rdy);
        bus.Upper_data = 9'(u);
        bus.Lower_data = 9'(lo);
        bus.Left_data  = 9'(le);
        bus.Right_data = 9'(r);
        bus.feat_ready = rdy;
        px(479, 271, 8'hff);
        bus.feat_ready = 1'b0;
        su = u; slo = lo; sle = le; sr = r;
    endtask

    task automatic accept(input string tag, input res_t held);
        bus.feat_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.feat_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.feat_valid), 0);
        check_res({tag, "_hold"}, held);
    endtask

    initial begin
        bus.wren = 1'b0; bus.data_in = 8'hff; bus.hcount = '0; bus.lcount = '0;
        bus.Upper_data = '0; bus.Lower_data = '0; bus.Left_data = '0; bus.Right_data = '0;
        bus.feat_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid",   32'(bus.feat_valid), 0);
        check("rst_overrun", 32'(bus.overrun),    0);
        check_res("rst", '{v: 0, h1: 0, h2: 0, err: 0, blk: 0});
        rst = 1'b0;

        // First frame end only arms the scan.
        fe(100, 200, 150, 250, 1'b0);
        check("first_fe_valid", 32'(bus.feat_valid), 0);

        // Digit "0" ring.
        drive_frame(1, 999);
        exp_q.push_back(model(1, su, slo, sle, sr));
        fe(100, 200, 150, 250, 1'b0);
        cur = exp_q.pop_front();
        check("ring_valid", 32'(bus.feat_valid), 1);
        check("ring_overrun", 32'(bus.overrun), 0);
        check_res("ring", cur);
        accept("ring_acc", cur);

        // Vertical bar "1".
        drive_frame(2, 999);
        exp_q.push_back(model(2, su, slo, sle, sr));
        fe(100, 200, 150, 250, 1'b0);
        cur = exp_q.pop_front();
        check("bar_valid", 32'(bus.feat_valid), 1);
        check_res("bar", cur);
        accept("bar_acc", cur);

        // Blank frame, then latch a degenerate box (Upper == Lower).
        drive_frame(0, 999);
        exp_q.push_back(model(0, su, slo, sle, sr));
        fe(50, 50, 150, 250, 1'b0);
        cur = exp_q.pop_front();
        check_res("blank", cur);
        accept("blank_acc", cur);

        // Black pixels during a degenerate box must not count.
        px(200, 50, 8'h00);
        px(200, 51, 8'h00);
        px(160, 60, 8'h10);
        exp_q.push_back(model(1, su, slo, sle, sr));
        fe(100, 200, 150, 250, 1'b0);
        cur = exp_q.pop_front();
        check("deg_valid", 32'(bus.feat_valid), 1);
        check_res("deg", cur);
        accept("deg_acc", cur);

        // Alternating row q1 saturates feat_h1; result left unaccepted.
        drive_frame(3, 999);
        exp_q.push_back(model(3, su, slo, sle, sr));
        fe(100, 200, 150, 250, 1'b0);
        cur = exp_q.pop_front();
        check_res("alt", cur);

        // Second frame end with ready low: result dropped, overrun pulses.
        drive_frame(1, 999);
        fe(100, 200, 150, 250, 1'b0);
        check("ovr_pulse", 32'(bus.overrun), 1);
        check("ovr_valid", 32'(bus.feat_valid), 1);
        check_res("ovr_hold", cur);
        @(posedge clock);
        #1;
        check("ovr_pulse_end", 32'(bus.overrun), 0);
        check("ovr_valid_hold", 32'(bus.feat_valid), 1);

        // Frame end coincident with acceptance: new result loads directly.
        drive_frame(2, 999);
        exp_q.push_back(model(2, su, slo, sle, sr));
        fe(100, 200, 150, 250, 1'b1);
        cur = exp_q.pop_front();
        check("coin_valid", 32'(bus.feat_valid), 1);
        check("coin_overrun", 32'(bus.overrun), 0);
        check_res("coin", cur);
        accept("coin_acc", cur);

        // Reset in the middle of a frame.
        drive_frame(1, 100);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.feat_valid), 0);
        check("mid_rst_overrun", 32'(bus.overrun), 0);
        check_res("mid_rst", '{v: 0, h1: 0, h2: 0, err: 0, blk: 0});
        @(posedge clock);
        #1;
        rst = 1'b0;
        fe(100, 200, 150, 250, 1'b0);
        check("post_rst_fe1_valid", 32'(bus.feat_valid), 0);
        drive_frame(2, 999);
        exp_q.push_back(model(2, su, slo, sle, sr));
        fe(100, 200, 150, 250, 1'b0);
        cur = exp_q.pop_front();
        check("post_rst_fe2_valid", 32'(bus.feat_valid), 1);
        check_res("post_rst", cur);
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
